// File: rtl/dac_burst_seq_pkg.sv
// dac_burst_seq_pkg: state encodings, conf bits and register map shared by the burst sequencer
package dac_burst_seq_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_PLAY, ST_GAP} seq_st_t;
    localparam int B_SEQ_ENA  = 0;
    localparam int B_SEQ_CONT = 1;
    localparam logic [7:0] R_SEQ_CONF  = 8'h40;
    localparam logic [7:0] R_SEQ_START = 8'h44;
    localparam logic [7:0] R_SEQ_LEN   = 8'h48;
    localparam logic [7:0] R_SEQ_DELAY = 8'h4C;
    localparam logic [7:0] R_SEQ_GAP   = 8'h50;
    localparam logic [7:0] R_SEQ_REP   = 8'h54;
    localparam logic [7:0] R_SEQ_MISS  = 8'h58;

    function automatic logic is_seq_reg(input logic [7:0] a);
        return a inside {R_SEQ_CONF, R_SEQ_START, R_SEQ_LEN, R_SEQ_DELAY, R_SEQ_GAP, R_SEQ_REP, R_SEQ_MISS};
    endfunction

    function automatic logic [1:0] seq_conf(input logic ena, input logic cont);
        logic [1:0] c;
        c = '0;
        c[B_SEQ_ENA] = ena;
        c[B_SEQ_CONT] = cont;
        return c;
    endfunction
endpackage

// File: rtl/dac_burst_seq_if.sv
// dac_burst_seq_if: config/trigger inputs and RAM-address/status outputs of the burst sequencer
interface dac_burst_seq_if #(
    parameter int AW = 13,
    parameter int CW = 16,
    parameter int RW = 8
);
    logic          i_ena;
    logic          i_cont;
    logic          i_sync;
    logic          i_soft_trig;
    logic [AW-1:0] i_start;
    logic [AW-1:0] i_len;
    logic [CW-1:0] i_delay;
    logic [CW-1:0] i_gap;
    logic [RW-1:0] i_rep;
    logic [AW-1:0] o_addr;
    logic          o_dvld;
    logic          o_busy;
    logic          o_done;
    logic          o_miss;
    logic [15:0]   o_miss_cnt;

    modport master (
        output i_ena, i_cont, i_sync, i_soft_trig, i_start, i_len, i_delay, i_gap, i_rep,
        input  o_addr, o_dvld, o_busy, o_done, o_miss, o_miss_cnt
    );
    modport slave (
        input  i_ena, i_cont, i_sync, i_soft_trig, i_start, i_len, i_delay, i_gap, i_rep,
        output o_addr, o_dvld, o_busy, o_done, o_miss, o_miss_cnt
    );
endinterface

// File: rtl/dac_burst_seq_sync_edge.sv
// dac_burst_seq_sync_edge: 2-FF synchroniser plus one-cycle rising-edge pulse for external sync inputs
module dac_burst_seq_sync_edge (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_d,
    output logic o_rise
);
    logic [2:0] s;

    always_ff @(posedge i_clk or posedge i_clr)
        if (i_clr) s <= '0;
        else s <= {s[1:0], i_d};

    assign o_rise = s[1] & ~s[2];
endmodule

// File: rtl/dac_burst_seq.sv
// dac_burst_seq: trigger-driven delay/burst/gap address sequencer feeding the DAC waveform RAM
module dac_burst_seq
    import dac_burst_seq_pkg::*;
#(
    parameter int AW  = 13,
    parameter int CW  = 16,
    parameter int RW  = 8,
    parameter int LAT = 1
) (
    input logic i_clk,
    input logic i_clr,
    dac_burst_seq_if.slave bus
);
    seq_st_t st;
    logic [AW-1:0] start, len, idx, addr;
    logic [CW-1:0] gap, dcnt, gcnt;
    logic [RW-1:0] rlast, rcnt;
    logic [LAT-1:0] vp, dp;
    logic [15:0] mcnt;
    logic armed, rise, trig, miss, miss_q, fin;

    dac_burst_seq_sync_edge u_sync (.i_clk(i_clk), .i_clr(i_clr), .i_d(bus.i_sync), .o_rise(rise));

    assign trig = rise | bus.i_soft_trig;
    assign miss = trig & (st != ST_IDLE);
    // final address of the run, or the end of delay for an empty burst; an abort never finishes
    assign fin = bus.i_ena & ((st == ST_PLAY & idx == len - 1'b1 & rcnt == rlast) |
                              (st == ST_DELAY & dcnt == '0 & len == '0));
    assign bus.o_addr = addr;
    assign bus.o_dvld = vp[LAT-1];
    assign bus.o_done = dp[LAT-1];
    assign bus.o_busy = st != ST_IDLE;
    assign bus.o_miss = miss_q;
    assign bus.o_miss_cnt = mcnt;

    always_ff @(posedge i_clk or posedge i_clr)
        if (i_clr) begin
            st <= ST_IDLE;
            start <= '0;
            len <= '0;
            idx <= '0;
            addr <= '0;
            gap <= '0;
            dcnt <= '0;
            gcnt <= '0;
            rlast <= '0;
            rcnt <= '0;
            vp <= '0;
            dp <= '0;
            mcnt <= '0;
            miss_q <= 1'b0;
            armed <= 1'b1;
        end else begin
            vp <= (vp << 1) | LAT'(st == ST_PLAY);
            dp <= (dp << 1) | LAT'(fin);
            miss_q <= miss;
            if (miss && mcnt != '1) mcnt <= mcnt + 1'b1;
            // single-shot disarms on completion; dropping enable re-arms
            armed <= ~bus.i_ena | (armed & ~(fin & ~bus.i_cont));
            if (st != ST_IDLE && !bus.i_ena) st <= ST_IDLE;
            else case (st)
                ST_IDLE:
                    if (trig && bus.i_ena && armed) begin
                        st <= ST_DELAY;
                        dcnt <= bus.i_delay;
                        start <= bus.i_start;
                        len <= bus.i_len;
                        gap <= bus.i_gap;
                        rlast <= bus.i_rep == '0 ? '0 : bus.i_rep - 1'b1;
                        rcnt <= '0;
                    end
                ST_DELAY:
                    if (dcnt != '0) dcnt <= dcnt - 1'b1;
                    else if (len == '0) st <= ST_IDLE;
                    else begin
                        st <= ST_PLAY;
                        idx <= '0;
                        addr <= start;
                    end
                ST_PLAY:
                    if (idx != len - 1'b1) begin
                        idx <= idx + 1'b1;
                        addr <= addr + 1'b1;
                    end else if (rcnt == rlast) st <= ST_IDLE;
                    else begin
                        rcnt <= rcnt + 1'b1;
                        idx <= '0;
                        // gap counts exact idle cycles, so zero gap restarts the burst directly
                        if (gap == '0) addr <= start;
                        else begin
                            st <= ST_GAP;
                            gcnt <= gap - 1'b1;
                        end
                    end
                ST_GAP:
                    if (gcnt != '0) gcnt <= gcnt - 1'b1;
                    else begin
                        st <= ST_PLAY;
                        addr <= start;
                    end
            endcase
        end
endmodule

// File: tb/tb_dac_burst_seq.sv
// tb_dac_burst_seq: scoreboard bench for dac_burst_seq; expected addresses/cycles queued at trigger time
module tb_dac_burst_seq;
    localparam int AW = 13;
    localparam int LAT = 1;

    typedef struct {
        int cyc;
        logic [AW-1:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int n_miss = 0;
    int t0, base;
    logic [AW-1:0] prev_addr;
    exp_t sq[$];
    int dq[$];
    exp_t e;

    dac_burst_seq_if #(.AW(AW), .CW(16), .RW(8)) bus ();
    dac_burst_seq #(.AW(AW), .CW(16), .RW(8), .LAT(LAT)) dut (.i_clk(clk), .i_clr(clr), .bus(bus.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk)
        if (!clr) begin
            if (bus.o_dvld) begin
                if (sq.size() == 0) check("dvld_spurious", bus.o_dvld, 0);
                else begin
                    e = sq.pop_front();
                    check("dvld_cyc", cyc, e.cyc);
                    check("addr", prev_addr, e.addr);
                end
            end
            if (bus.o_done) begin
                if (dq.size() == 0) check("done_spurious", bus.o_done, 0);
                else check("done_cyc", cyc, dq.pop_front());
            end
            if (bus.o_miss) n_miss++;
            prev_addr = bus.o_addr;
        end

    task automatic push_run(input int t, input int st, input int len, input int dly, input int gp, input int rp);
        exp_t x;
        int c = t + dly + 2 + LAT;
        int r = rp == 0 ? 1 : rp;
        for (int b = 0; b < r; b++) begin
            for (int i = 0; i < len; i++) begin
                x.cyc = c;
                x.addr = AW'(st + i);
                sq.push_back(x);
                c++;
            end
            if (b < r - 1) c += gp;
        end
        dq.push_back(len == 0 ? t + dly + 1 + LAT : c - 1);
    endtask

    task automatic fire(input int st, input int len, input int dly, input int gp, input int rp, output int t);
        @(negedge clk);
        bus.i_start = AW'(st);
        bus.i_len = AW'(len);
        bus.i_delay = 16'(dly);
        bus.i_gap = 16'(gp);
        bus.i_rep = 8'(rp);
        bus.i_soft_trig = 1'b1;
        t = cyc;
        push_run(t, st, len, dly, gp, rp);
        @(negedge clk);
        bus.i_soft_trig = 1'b0;
        check("busy_on", bus.o_busy, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (sq.size() + dq.size()) != 0; i++) @(negedge clk);
        check("drain", sq.size() + dq.size(), 0);
        repeat (3) @(negedge clk);
        check("busy_off", bus.o_busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        {bus.i_ena, bus.i_cont, bus.i_sync, bus.i_soft_trig} = '0;
        {bus.i_start, bus.i_len, bus.i_delay, bus.i_gap, bus.i_rep} = '0;
        repeat (3) @(negedge clk);
        check("rst_addr", bus.o_addr, 0);
        check("rst_dvld", bus.o_dvld, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_done", bus.o_done, 0);
        check("rst_miss", bus.o_miss, 0);
        check("rst_miss_cnt", bus.o_miss_cnt, 0);
        clr = 1'b0;
        bus.i_ena = 1'b1;
        bus.i_cont = 1'b1;
        fire(12'h100, 4, 0, 0, 1, t0);
        drain();
        fire(13'h1FFE, 4, 0, 0, 1, t0);
        drain();
        fire(12'h200, 3, 0, 2, 3, t0);
        drain();
        fire(12'h200, 3, 0, 0, 3, t0);
        drain();
        fire(12'h400, 2, 3, 5, 0, t0);
        drain();
        base = n_miss;
        fire(12'h300, 20, 0, 0, 1, t0);
        repeat (3) @(negedge clk);
        #2 bus.i_sync = 1'b1;
        #30 bus.i_sync = 1'b0;
        drain();
        check("miss_pulses", n_miss - base, 1);
        check("miss_cnt", bus.o_miss_cnt, 1);
        fire(12'h500, 8, 0, 0, 1, t0);
        repeat (3) @(negedge clk);
        bus.i_ena = 1'b0;
        while (sq.size() != 0 && sq[$].cyc > t0 + 5) void'(sq.pop_back());
        dq.delete();
        @(negedge clk);
        check("abort_busy", bus.o_busy, 0);
        check("abort_dvld_drain", bus.o_dvld, 1);
        @(negedge clk);
        check("abort_dvld_end", bus.o_dvld, 0);
        drain();
        bus.i_ena = 1'b1;
        fire(12'h600, 4, 20, 0, 1, t0);
        repeat (3) @(negedge clk);
        check("clr_pre_busy", bus.o_busy, 1);
        #2 clr = 1'b1;
        #1;
        check("clr_busy", bus.o_busy, 0);
        check("clr_addr", bus.o_addr, 0);
        check("clr_miss_cnt", bus.o_miss_cnt, 0);
        check("clr_dvld", bus.o_dvld, 0);
        sq.delete();
        dq.delete();
        @(negedge clk);
        clr = 1'b0;
        fire(12'h700, 0, 5, 1, 2, t0);
        drain();
        fire(12'h700, 0, 5, 1, 2, t0);
        drain();
        bus.i_cont = 1'b0;
        fire(12'h800, 2, 0, 0, 1, t0);
        drain();
        @(negedge clk);
        bus.i_soft_trig = 1'b1;
        @(negedge clk);
        bus.i_soft_trig = 1'b0;
        check("oneshot_ignored", bus.o_busy, 0);
        check("oneshot_nomiss", bus.o_miss_cnt, 0);
        bus.i_ena = 1'b0;
        @(negedge clk);
        bus.i_ena = 1'b1;
        fire(12'h810, 3, 1, 0, 1, t0);
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
